// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard controller
// and the units that reuse its load-use comparator.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        ERROR      = 2'd3
    } state_t;

    // What the pipeline does this cycle; each maps to one enable/flush pattern.
    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_REDIRECT,
        ACT_FREEZE,
        ACT_BUBBLE,
        ACT_RESET
    } action_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         DEF_LOAD_BUBBLES = 1;
    localparam int         DEF_MEM_TIMEOUT  = 15;
    localparam int         BUBBLE_W         = 3;
    localparam int         WAIT_W           = 8;

    function automatic ctrl_t ctrl_for(action_t act);
        ctrl_t c;
        c = '0;
        unique case (act)
            ACT_RUN: begin
                c.pc_write     = 1'b1;
                c.if_id_write  = 1'b1;
                c.id_ex_write  = 1'b1;
                c.ex_mem_write = 1'b1;
            end
            ACT_REDIRECT: begin
                c.pc_write     = 1'b1;
                c.if_id_write  = 1'b1;
                c.id_ex_write  = 1'b1;
                c.ex_mem_write = 1'b1;
                c.if_id_flush  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_flush = 1'b1;
            end
            ACT_BUBBLE: begin
                c.id_ex_write  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_write = 1'b1;
            end
            ACT_FREEZE: begin
                c.mem_wb_flush = 1'b1;
            end
            default: begin
                c.if_id_flush  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_flush = 1'b1;
                c.mem_wb_flush = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline status in, register enables/flushes and error/perf counters out.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             MemRead_ID_EX;
    logic [4:0]       rt_ID_EX;
    logic [4:0]       rs_IF_ID;
    logic [4:0]       rt_IF_ID;
    logic             uses_rt_IF_ID;
    logic             branch_taken_MEM;
    logic             jump_MEM;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output MemRead_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, uses_rt_IF_ID,
               branch_taken_MEM, jump_MEM, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_flush, mem_err,
               stall_cycles, flush_events
    );

    modport slave (
        input  MemRead_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, uses_rt_IF_ID,
               branch_taken_MEM, jump_MEM, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_flush, mem_err,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use comparator: the ID instruction needs a register still being loaded in EX.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] rt_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt,
    output logic       load_use
);
    // $zero is never a real dependency even when a load targets it.
    assign load_use = mem_read && (rt_ex != REG_ZERO) &&
                      ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirects, data-memory waits,
// load-use bubbles, memory timeout error and saturating perf counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = DEF_LOAD_BUBBLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);

    state_t              state;
    logic [BUBBLE_W-1:0] bubble_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_err;
    logic [CNT_W-1:0]    stall_cycles;
    logic [CNT_W-1:0]    flush_events;

    logic    load_use;
    logic    redirect;
    logic    mem_stall;
    action_t action;
    ctrl_t   ctrl;

    load_use_detect u_load_use (
        .mem_read (hz.MemRead_ID_EX),
        .rt_ex    (hz.rt_ID_EX),
        .rs_id    (hz.rs_IF_ID),
        .rt_id    (hz.rt_IF_ID),
        .uses_rt  (hz.uses_rt_IF_ID),
        .load_use (load_use)
    );

    assign redirect  = hz.branch_taken_MEM | hz.jump_MEM;
    assign mem_stall = hz.mem_req & ~hz.mem_ready;

    // NOTE: action gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        action = ACT_RUN;
        if (reset) begin
            action = ACT_RESET;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect)       action = ACT_REDIRECT;
                    else if (mem_stall) action = ACT_FREEZE;
                    else if (load_use)  action = ACT_BUBBLE;
                end
                LOAD_STALL: action = redirect ? ACT_REDIRECT : ACT_BUBBLE;
                MEM_WAIT:   action = hz.mem_ready ? ACT_RUN : ACT_FREEZE;
                ERROR:      action = ACT_FREEZE;
                default:    action = ACT_FREEZE;
            endcase
        end
    end

    assign ctrl = ctrl_for(action);

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            bubble_cnt   <= '0;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (redirect) begin
                        state <= RUN;
                    end else if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if (load_use && (LOAD_BUBBLES > 1)) begin
                        state      <= LOAD_STALL;
                        bubble_cnt <= BUBBLE_W'(LOAD_BUBBLES - 1);
                    end
                end
                LOAD_STALL: begin
                    if (redirect || (bubble_cnt <= BUBBLE_W'(1))) begin
                        state      <= RUN;
                        bubble_cnt <= '0;
                    end else begin
                        bubble_cnt <= bubble_cnt - BUBBLE_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state   <= ERROR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ERROR;
            endcase

            if (!ctrl.pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if ((action == ACT_REDIRECT) && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

    assign hz.pc_write     = ctrl.pc_write;
    assign hz.if_id_write  = ctrl.if_id_write;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_write  = ctrl.id_ex_write;
    assign hz.id_ex_flush  = ctrl.id_ex_flush;
    assign hz.ex_mem_write = ctrl.ex_mem_write;
    assign hz.ex_mem_flush = ctrl.ex_mem_flush;
    assign hz.mem_wb_flush = ctrl.mem_wb_flush;
    assign hz.mem_err      = mem_err;
    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_events = flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (1 bubble, 3 bubbles,
// 4-bit counters) share one stimulus stream; each test checks the relevant one.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       mr;
        logic [4:0] rt_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       uses_rt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       rdy;
    } stim_t;

    // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f}
    localparam logic [7:0] O_DEF   = 8'b1101_0100;
    localparam logic [7:0] O_RST   = 8'b0010_1011;
    localparam logic [7:0] O_LU    = 8'b0001_1100;
    localparam logic [7:0] O_REDIR = 8'b1111_1110;
    localparam logic [7:0] O_FRZ   = 8'b0000_0001;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_b ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if_c ();

    pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(15), .CNT_W(16))
        dut_a (.clk(clk), .reset(reset), .hz(if_a));
    pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(15), .CNT_W(16))
        dut_b (.clk(clk), .reset(reset), .hz(if_b));
    pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(15), .CNT_W(4))
        dut_c (.clk(clk), .reset(reset), .hz(if_c));

    logic [7:0] ov_a, ov_b, ov_c;
    assign ov_a = {if_a.pc_write, if_a.if_id_write, if_a.if_id_flush, if_a.id_ex_write,
                   if_a.id_ex_flush, if_a.ex_mem_write, if_a.ex_mem_flush, if_a.mem_wb_flush};
    assign ov_b = {if_b.pc_write, if_b.if_id_write, if_b.if_id_flush, if_b.id_ex_write,
                   if_b.id_ex_flush, if_b.ex_mem_write, if_b.ex_mem_flush, if_b.mem_wb_flush};
    assign ov_c = {if_c.pc_write, if_c.if_id_write, if_c.if_id_flush, if_c.id_ex_write,
                   if_c.id_ex_flush, if_c.ex_mem_write, if_c.ex_mem_flush, if_c.mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        if_a.MemRead_ID_EX = s.mr;  if_b.MemRead_ID_EX = s.mr;  if_c.MemRead_ID_EX = s.mr;
        if_a.rt_ID_EX = s.rt_ex;    if_b.rt_ID_EX = s.rt_ex;    if_c.rt_ID_EX = s.rt_ex;
        if_a.rs_IF_ID = s.rs_id;    if_b.rs_IF_ID = s.rs_id;    if_c.rs_IF_ID = s.rs_id;
        if_a.rt_IF_ID = s.rt_id;    if_b.rt_IF_ID = s.rt_id;    if_c.rt_IF_ID = s.rt_id;
        if_a.uses_rt_IF_ID = s.uses_rt; if_b.uses_rt_IF_ID = s.uses_rt; if_c.uses_rt_IF_ID = s.uses_rt;
        if_a.branch_taken_MEM = s.br; if_b.branch_taken_MEM = s.br; if_c.branch_taken_MEM = s.br;
        if_a.jump_MEM = s.jmp;      if_b.jump_MEM = s.jmp;      if_c.jump_MEM = s.jmp;
        if_a.mem_req = s.req;       if_b.mem_req = s.req;       if_c.mem_req = s.req;
        if_a.mem_ready = s.rdy;     if_b.mem_ready = s.rdy;     if_c.mem_ready = s.rdy;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0);
        cycle();
        reset = 1'b0;
    endtask

    stim_t idle, lu5, lu0, lu_rt, lu_nort, mw, mw_rdy;
    int    stalls;

    initial begin
        idle    = '0;
        lu5     = '0; lu5.mr = 1'b1; lu5.rt_ex = 5'd5; lu5.rs_id = 5'd5;
        lu0     = '0; lu0.mr = 1'b1;
        lu_rt   = '0; lu_rt.mr = 1'b1; lu_rt.rt_ex = 5'd7; lu_rt.rs_id = 5'd3;
        lu_rt.rt_id = 5'd7; lu_rt.uses_rt = 1'b1;
        lu_nort = lu_rt; lu_nort.uses_rt = 1'b0;
        mw      = '0; mw.req = 1'b1;
        mw_rdy  = mw; mw_rdy.rdy = 1'b1;

        // Reset forces every write low and every flush high.
        reset = 1'b1;
        drive(idle);
        check("rst_outputs", 32'(ov_a), 32'(O_RST));
        cycle();
        reset = 1'b0;
        drive(idle);
        check("rst_defaults", 32'(ov_a), 32'(O_DEF));
        check("rst_stall_cnt", 32'(if_a.stall_cycles), 0);
        check("rst_mem_err", 32'(if_a.mem_err), 0);

        // Single-bubble load-use on rs, then $zero destination does not stall.
        drive(lu5);
        check("lu1_bubble", 32'(ov_a), 32'(O_LU));
        cycle();
        drive(idle);
        check("lu1_after", 32'(ov_a), 32'(O_DEF));
        check("lu1_stall_cnt", 32'(if_a.stall_cycles), 1);
        drive(lu0);
        check("lu_r0_nostall", 32'(ov_a), 32'(O_DEF));
        cycle();
        check("lu_r0_stall_cnt", 32'(if_a.stall_cycles), 1);

        // RUN priority: redirect over memory wait over load-use.
        begin
            stim_t s;
            s = lu5; s.br = 1'b1; s.req = 1'b1;
            drive(s);
            check("prio_redirect", 32'(ov_a), 32'(O_REDIR));
            s.br = 1'b0;
            drive(s);
            check("prio_memwait", 32'(ov_a), 32'(O_FRZ));
        end

        // Three-bubble stall via rt compare; repeat with uses_rt low.
        do_reset();
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i == 0 ? lu_rt : idle);
            check($sformatf("lu3_c%0d", i), 32'(ov_b), 32'(i < 3 ? O_LU : O_DEF));
            if (!if_b.pc_write) stalls++;
            cycle();
        end
        check("lu3_stalls_seen", 32'(stalls), 3);
        check("lu3_stall_cnt", 32'(if_b.stall_cycles), 3);
        do_reset();
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i == 0 ? lu_nort : idle);
            if (!if_b.pc_write) stalls++;
            cycle();
        end
        check("nort_stalls_seen", 32'(stalls), 0);
        check("nort_stall_cnt", 32'(if_b.stall_cycles), 0);

        // Jump in the second bubble cycle wins and ends the stall.
        do_reset();
        drive(lu_rt);
        check("rds_c0", 32'(ov_b), 32'(O_LU));
        cycle();
        begin
            stim_t s;
            s = idle; s.jmp = 1'b1;
            drive(s);
        end
        check("rds_c1_redirect", 32'(ov_b), 32'(O_REDIR));
        cycle();
        drive(idle);
        check("rds_c2_default", 32'(ov_b), 32'(O_DEF));
        check("rds_flush_cnt", 32'(if_b.flush_events), 1);
        check("rds_stall_cnt", 32'(if_b.stall_cycles), 1);
        cycle();
        check("rds_c3_default", 32'(ov_b), 32'(O_DEF));

        // Four wait cycles then ready; a redirect mid-wait is ignored.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            stim_t s;
            s = (i == 4) ? mw_rdy : mw;
            s.jmp = (i == 2);
            drive(s);
            check($sformatf("mw_c%0d", i), 32'(ov_a), 32'(i < 4 ? O_FRZ : O_DEF));
            cycle();
        end
        drive(idle);
        check("mw_stall_cnt", 32'(if_a.stall_cycles), 4);
        check("mw_flush_cnt", 32'(if_a.flush_events), 0);
        check("mw_after", 32'(ov_a), 32'(O_DEF));

        // Timeout: error after the 15th MEM_WAIT cycle, sticky through mem_ready.
        do_reset();
        drive(mw);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("to_noerr_%0d", k), 32'(if_a.mem_err), 0);
            cycle();
        end
        check("to_err_set", 32'(if_a.mem_err), 1);
        drive(mw_rdy);
        check("to_err_frozen", 32'(ov_a), 32'(O_FRZ));
        cycle();
        check("to_err_sticky", 32'(if_a.mem_err), 1);
        check("to_stall_cnt", 32'(if_a.stall_cycles), 17);
        reset = 1'b1;
        drive(mw_rdy);
        check("to_rst_outputs", 32'(ov_a), 32'(O_RST));
        cycle();
        reset = 1'b0;
        drive(idle);
        check("to_rst_err", 32'(if_a.mem_err), 0);
        check("to_rst_stall", 32'(if_a.stall_cycles), 0);
        check("to_rst_flush", 32'(if_a.flush_events), 0);
        check("to_rst_run", 32'(ov_a), 32'(O_DEF));

        // 4-bit stall counter saturates at 15.
        do_reset();
        drive(lu5);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i == 13) check("sat_14", 32'(if_c.stall_cycles), 14);
        end
        check("sat_15", 32'(if_c.stall_cycles), 15);
        check("sat_still_lu", 32'(ov_c), 32'(O_LU));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
